// File: rtl/hack_rom_loader.sv
// Program loader and instruction ROM for hCPU: receives a length-prefixed, checksummed
// byte stream, stores it as 16-bit words and serves combinational fetches once verified.
module hack_rom_loader #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [15:0]           pc,
    output logic [15:0]           instruction,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int          DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [16:0] DEPTH_W = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_LEN_HI  = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_CHECK   = 3'd4,
        ST_RUN     = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          chk_q, chk_d;
    logic [7:0]          hold_q, hold_d;
    logic [ADDR_WIDTH:0] word_count_q, word_count_d;

    logic [15:0]         mem_q [DEPTH];

    logic                accept_s;
    logic                mem_we_s;
    logic [15:0]         len_new_s;
    logic [ADDR_WIDTH:0] wc_inc_s;
    logic [16:0]         wc_inc_ext_s;
    logic [16:0]         wc_ext_s;
    logic                pc_in_range_s;
    logic                rx_ready_s;
    logic                cpu_reset_s;
    logic                load_done_s;
    logic                error_s;

    assign accept_s     = rx_valid & rx_ready_s;
    assign len_new_s    = {len_q[15:8], rx_data};
    assign wc_inc_s     = word_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign wc_inc_ext_s = {{(16 - ADDR_WIDTH){1'b0}}, wc_inc_s};
    assign wc_ext_s     = {{(16 - ADDR_WIDTH){1'b0}}, word_count_q};

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LEN_HI;
            len_q        <= 16'h0000;
            chk_q        <= 8'h00;
            hold_q       <= 8'h00;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            chk_q        <= chk_d;
            hold_q       <= hold_d;
            word_count_q <= word_count_d;
        end
    end

    // Word memory write port; contents survive reset and are hidden by word_count gating
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[word_count_q[ADDR_WIDTH-1:0]] <= {hold_q, rx_data};
        end
    end

    // Next-state and datapath update, advancing only on an accepted byte
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        chk_d        = chk_q;
        hold_d       = hold_q;
        word_count_d = word_count_q;
        mem_we_s     = 1'b0;
        if (accept_s) begin
            case (state_q)
                ST_LEN_HI: begin
                    len_d   = {rx_data, 8'h00};
                    chk_d   = rx_data;
                    state_d = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_d = len_new_s;
                    chk_d = chk_q + rx_data;
                    if ((len_new_s == 16'h0000) || ({1'b0, len_new_s} > DEPTH_W)) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    hold_d  = rx_data;
                    chk_d   = chk_q + rx_data;
                    state_d = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    mem_we_s     = 1'b1;
                    word_count_d = wc_inc_s;
                    chk_d        = chk_q + rx_data;
                    if (wc_inc_ext_s == {1'b0, len_q}) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
                ST_CHECK: begin
                    if (rx_data == chk_q) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Status outputs decoded from the registered state only
    always_comb begin
        rx_ready_s  = 1'b0;
        cpu_reset_s = 1'b1;
        load_done_s = 1'b0;
        error_s     = 1'b0;
        case (state_q)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK: begin
                rx_ready_s = 1'b1;
            end
            ST_RUN: begin
                cpu_reset_s = 1'b0;
                load_done_s = 1'b1;
            end
            ST_ERROR: begin
                error_s = 1'b1;
            end
            default: begin
                rx_ready_s = 1'b0;
            end
        endcase
    end

    // Fetch is visible only for addresses inside a completed image
    always_comb begin
        pc_in_range_s = ({1'b0, pc} < wc_ext_s) && (pc[15:ADDR_WIDTH] == '0);
        if ((state_q == ST_RUN) && pc_in_range_s) begin
            instruction = mem_q[pc[ADDR_WIDTH-1:0]];
        end else begin
            instruction = 16'h0000;
        end
    end

    assign rx_ready   = rx_ready_s;
    assign cpu_reset  = cpu_reset_s;
    assign load_done  = load_done_s;
    assign error      = error_s;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader: a full-size instance plus a 16-word instance for
// length-boundary checks.
module tb_hack_rom_loader;

    logic        clock = 1'b0;
    logic        a_reset, b_reset;
    logic [7:0]  a_rx_data, b_rx_data;
    logic        a_rx_valid, b_rx_valid;
    logic        a_rx_ready, b_rx_ready;
    logic [15:0] a_pc, b_pc;
    logic [15:0] a_instruction, b_instruction;
    logic        a_cpu_reset, b_cpu_reset;
    logic        a_load_done, b_load_done;
    logic        a_error, b_error;
    logic [15:0] a_word_count;
    logic [4:0]  b_word_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] chk_acc;

    always #5 clock = ~clock;

    hack_rom_loader #(.ADDR_WIDTH(15)) dut_a (
        .clock(clock), .reset(a_reset), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
        .rx_ready(a_rx_ready), .pc(a_pc), .instruction(a_instruction),
        .cpu_reset(a_cpu_reset), .load_done(a_load_done), .error(a_error),
        .word_count(a_word_count)
    );

    hack_rom_loader #(.ADDR_WIDTH(4)) dut_b (
        .clock(clock), .reset(b_reset), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .rx_ready(b_rx_ready), .pc(b_pc), .instruction(b_instruction),
        .cpu_reset(b_cpu_reset), .load_done(b_load_done), .error(b_error),
        .word_count(b_word_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input int which, input logic [7:0] b);
        @(negedge clock);
        if (which == 0) begin
            a_rx_data = b; a_rx_valid = 1'b1;
        end else begin
            b_rx_data = b; b_rx_valid = 1'b1;
        end
        @(posedge clock);
        #1;
        a_rx_valid = 1'b0;
        b_rx_valid = 1'b0;
        a_rx_data  = 8'($urandom);
        b_rx_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            a_rx_valid = 1'b0;
            a_rx_data  = 8'($urandom);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset(input int which);
        @(negedge clock);
        if (which == 0) a_reset = 1'b1; else b_reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        if (which == 0) a_reset = 1'b0; else b_reset = 1'b0;
    endtask

    task automatic send_good(input int stall);
        logic [7:0] s [7];
        s = '{8'h00, 8'h02, 8'h00, 8'h05, 8'hEC, 8'h10, 8'h03};
        for (int i = 0; i < 7; i++) begin
            if (stall != 0) idle(int'($urandom_range(0, 3)));
            send(0, s[i]);
        end
    endtask

    task automatic check_good(input string tag);
        check({tag, "_done"},  32'(a_load_done), 32'd1);
        check({tag, "_cpurst"}, 32'(a_cpu_reset), 32'd0);
        check({tag, "_ready"}, 32'(a_rx_ready), 32'd0);
        check({tag, "_err"},   32'(a_error), 32'd0);
        check({tag, "_wc"},    32'(a_word_count), 32'd2);
        a_pc = 16'd0; #1; check({tag, "_pc0"}, 32'(a_instruction), 32'h0005);
        a_pc = 16'd1; #1; check({tag, "_pc1"}, 32'(a_instruction), 32'hEC10);
        a_pc = 16'd2; #1; check({tag, "_pc2"}, 32'(a_instruction), 32'h0000);
        a_pc = 16'h8000; #1; check({tag, "_pchi"}, 32'(a_instruction), 32'h0000);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_rx_valid = 1'b0; b_rx_valid = 1'b0;
        a_rx_data = 8'h00; b_rx_data = 8'h00;
        a_pc = 16'h0000; b_pc = 16'h0000;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready",  32'(a_rx_ready), 32'd1);
        check("rst_cpurst", 32'(a_cpu_reset), 32'd1);
        check("rst_done",   32'(a_load_done), 32'd0);
        check("rst_err",    32'(a_error), 32'd0);
        check("rst_wc",     32'(a_word_count), 32'd0);
        check("rst_instr",  32'(a_instruction), 32'h0000);
        @(negedge clock);
        a_reset = 1'b0; b_reset = 1'b0;

        // Scenario 1: good load
        send(0, 8'h00); send(0, 8'h02); send(0, 8'h00); send(0, 8'h05);
        send(0, 8'hEC); send(0, 8'h10);
        check("s1_pre_cpurst", 32'(a_cpu_reset), 32'd1);
        check("s1_pre_wc",     32'(a_word_count), 32'd2);
        check("s1_pre_ready",  32'(a_rx_ready), 32'd1);
        a_pc = 16'd0; #1; check("s1_pre_instr", 32'(a_instruction), 32'h0000);
        send(0, 8'h03);
        check_good("s1");
        idle(3);
        check("s1_idle_done", 32'(a_load_done), 32'd1);

        // Scenario 2: bad checksum; old memory must stay hidden
        do_reset(0);
        send(0, 8'h00); send(0, 8'h02); send(0, 8'h00); send(0, 8'h05);
        send(0, 8'hEC); send(0, 8'h10); send(0, 8'h04);
        check("s2_err",    32'(a_error), 32'd1);
        check("s2_done",   32'(a_load_done), 32'd0);
        check("s2_cpurst", 32'(a_cpu_reset), 32'd1);
        check("s2_ready",  32'(a_rx_ready), 32'd0);
        a_pc = 16'd0; #1; check("s2_pc0", 32'(a_instruction), 32'h0000);
        a_pc = 16'd1; #1; check("s2_pc1", 32'(a_instruction), 32'h0000);

        // Scenario 3: length boundaries
        do_reset(0);
        send(0, 8'h00);
        check("s3_zero_first", 32'(a_error), 32'd0);
        send(0, 8'h00);
        check("s3_zero_err", 32'(a_error), 32'd1);
        send(1, 8'h00); send(1, 8'h11);
        check("s3_n17_err", 32'(b_error), 32'd1);
        check("s3_n17_ready", 32'(b_rx_ready), 32'd0);
        do_reset(1);
        chk_acc = 8'h10;
        send(1, 8'h00); send(1, 8'h10);
        check("s3_n16_err",   32'(b_error), 32'd0);
        check("s3_n16_ready", 32'(b_rx_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            send(1, 8'(i));
            send(1, ~8'(i));
            chk_acc = chk_acc + 8'(i) + ~8'(i);
        end
        check("s3_n16_chk_model", 32'(chk_acc), 32'h00);
        send(1, chk_acc);
        check("s3_n16_done", 32'(b_load_done), 32'd1);
        check("s3_n16_wc",   32'(b_word_count), 32'd16);
        b_pc = 16'd15; #1; check("s3_pc15", 32'(b_instruction), 32'h0FF0);
        b_pc = 16'd3;  #1; check("s3_pc3",  32'(b_instruction), 32'h03FC);
        b_pc = 16'd16; #1; check("s3_pc16", 32'(b_instruction), 32'h0000);
        b_pc = 16'h8003; #1; check("s3_pchi", 32'(b_instruction), 32'h0000);

        // Scenario 4: stalls with garbage data between bytes
        do_reset(0);
        send_good(1);
        check_good("s4");

        // Scenario 5: asynchronous reset mid-load
        do_reset(0);
        send(0, 8'h00); send(0, 8'h02); send(0, 8'h00);
        #2; a_reset = 1'b1;
        #1;
        check("s5_rst_ready",  32'(a_rx_ready), 32'd1);
        check("s5_rst_cpurst", 32'(a_cpu_reset), 32'd1);
        check("s5_rst_wc",     32'(a_word_count), 32'd0);
        check("s5_rst_err",    32'(a_error), 32'd0);
        a_reset = 1'b0;
        send_good(0);
        check_good("s5");

        // Scenario 6: reset in RUN, then a one-word image
        do_reset(0);
        check("s6_rst_done", 32'(a_load_done), 32'd0);
        send(0, 8'h00); send(0, 8'h01); send(0, 8'hFF); send(0, 8'hFF); send(0, 8'hFF);
        check("s6_done", 32'(a_load_done), 32'd1);
        check("s6_wc",   32'(a_word_count), 32'd1);
        a_pc = 16'd0; #1; check("s6_pc0", 32'(a_instruction), 32'hFFFF);
        a_pc = 16'd1; #1; check("s6_pc1", 32'(a_instruction), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
